// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete immediately with result 0.
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] RS1_i,
  input  logic [XLEN-1:0] RS2_i,
  input  logic [4:0]      RDaddr_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      RDaddr_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opa_q, opa_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [4:0]          rdl_q, rdl_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [4:0]          rdo_q, rdo_d;

  logic                a_sgn, b_sgn, a_neg, b_neg, special;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic [XLEN:0]       sum;
  logic [2*XLEN-1:0]   mul_nx, step_nx, prod;
  logic [XLEN-1:0]     mul_res, div_res, final_res;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]       shifted, part;
  logic                ge;
  logic [2*XLEN-1:0]   div_nx;
  logic [XLEN-1:0]     div_sel;
`endif

  // Operand decode: MUL/MULH signed x signed, MULHSU signed x unsigned, *U unsigned.
  always_comb begin
    a_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn = op_i[2] ? ~op_i[0] : ~op_i[1];
    a_neg = a_sgn & RS1_i[XLEN-1];
    b_neg = b_sgn & RS2_i[XLEN-1];
    a_mag = a_neg ? -RS1_i : RS1_i;
    b_mag = b_neg ? -RS2_i : RS2_i;
`ifdef MULDIV_DIV_EN
    special = op_i[2] & ((RS2_i == '0) |
              (~op_i[0] & (RS1_i == {1'b1, {(XLEN-1){1'b0}}}) & (RS2_i == '1)));
    if (RS2_i == '0) special_res = op_i[1] ? RS1_i : '1;
    else             special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`else
    special     = op_i[2];
    special_res = '0;
`endif
  end

  // One iteration; acc holds {high partial, low shift register}.
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_nx = {sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge      = shifted >= {1'b0, opa_q};
    part    = ge ? shifted - {1'b0, opa_q} : shifted;
    div_nx  = {part[XLEN-1:0], acc_q[XLEN-2:0], ge};
    step_nx = op_q[2] ? div_nx : mul_nx;
    div_sel = op_q[1] ? step_nx[2*XLEN-1:XLEN] : step_nx[XLEN-1:0];
    div_res = neg_q ? -div_sel : div_sel;
`else
    step_nx = mul_nx;
    div_res = '0;
`endif
    prod      = neg_q ? -step_nx : step_nx;
    mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    final_res = op_q[2] ? div_res : mul_res;
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    neg_d = neg_q;
    opa_d = opa_q;
    acc_d = acc_q;
    rdl_d = rdl_q;
    res_d = res_q;
    rdo_d = rdo_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        cnt_d = '0;
        op_d  = op_i;
        rdl_d = RDaddr_i;
        if (op_i[2]) begin
          opa_d = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          neg_d = op_i[1] ? a_neg : (a_neg ^ b_neg);
        end else begin
          opa_d = a_mag;
          acc_d = {{XLEN{1'b0}}, b_mag};
          neg_d = a_neg ^ b_neg;
        end
        if (special) begin
          res_d = special_res;
          rdo_d = RDaddr_i;
        end
      end
      BUSY: begin
        acc_d = step_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d = final_res;
          rdo_d = rdl_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opa_q   <= '0;
      acc_q   <= '0;
      rdl_q   <= '0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      rdl_q   <= rdl_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = special ? DONE : BUSY;
      BUSY:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o  = ((state_q == IDLE) & start_i) | (state_q == BUSY);
    done_o   = (state_q == DONE);
    result_o = res_q;
    RDaddr_o = rdo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (expectations follow MULDIV_DIV_EN).
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] RS1_i, RS2_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  RDaddr_o;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .RS1_i(RS1_i), .RS2_i(RS2_i), .RDaddr_i(RDaddr_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .RDaddr_o(RDaddr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Drives one instruction and measures latency to done_o (0 = never came).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output int lat, output int stall_bad);
    @(negedge clk_i);
    op_i = op; RS1_i = a; RS2_i = b; RDaddr_i = rd; start_i = 1'b1;
    #1;
    stall_bad = (stall_o !== 1'b1) ? 1 : 0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        lat = i;
        break;
      end
      if (stall_o !== 1'b1) stall_bad++;
    end
    if (lat != 0 && stall_o !== 1'b0) stall_bad++;
    res = result_o;
    rdo = RDaddr_o;
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; start_i = 1'b0; op_i = '0; RS1_i = '0; RS2_i = '0; RDaddr_i = '0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result_o); end
    checks++; if (RDaddr_o !== 5'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", RDaddr_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4];
    logic [31:0] as [4], bs [4], exps [4];
    logic [31:0] res; logic [4:0] rdo; int lat, sb;
    ops[0] = 3'b000; as[0] = 32'd7;        bs[0] = 32'd6;        exps[0] = 32'd42;
    ops[1] = 3'b001; as[1] = 32'hFFFFFFFF; bs[1] = 32'hFFFFFFFF; exps[1] = 32'h00000000;
    ops[2] = 3'b011; as[2] = 32'hFFFFFFFF; bs[2] = 32'hFFFFFFFF; exps[2] = 32'hFFFFFFFE;
    ops[3] = 3'b010; as[3] = 32'hFFFFFFFF; bs[3] = 32'hFFFFFFFF; exps[3] = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      do_op(ops[k], as[k], bs[k], 5'(k + 5), res, rdo, lat, sb);
      checks++; if (res !== exps[k]) begin errors++; $display("FAIL mul_res[%0d] got %h exp %h", k, res, exps[k]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL mul_lat[%0d] got %0d exp 33", k, lat); end
      checks++; if (sb != 0) begin errors++; $display("FAIL mul_stall[%0d] got %0d bad cycles exp 0", k, sb); end
      checks++; if (rdo !== 5'(k + 5)) begin errors++; $display("FAIL mul_rd[%0d] got %0d exp %0d", k, rdo, k + 5); end
    end
    repeat (3) @(negedge clk_i);
    checks++; if (result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL result_hold got %h exp ffffffff", result_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", done_o); end
  endtask

  task automatic test_div;
    logic [2:0]  ops [7];
    logic [31:0] as [7], bs [7], exps [7];
    int          lats [7];
    logic [31:0] res; logic [4:0] rdo; int lat, sb;
`ifdef MULDIV_DIV_EN
    ops[0] = 3'b100; as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;        exps[0] = 32'hFFFFFFFD; lats[0] = 33;
    ops[1] = 3'b110; as[1] = 32'hFFFFFFF9; bs[1] = 32'd2;        exps[1] = 32'hFFFFFFFF; lats[1] = 33;
    ops[2] = 3'b101; as[2] = 32'd100;      bs[2] = 32'd7;        exps[2] = 32'd14;       lats[2] = 33;
    ops[3] = 3'b111; as[3] = 32'd100;      bs[3] = 32'd7;        exps[3] = 32'd2;        lats[3] = 33;
    ops[4] = 3'b101; as[4] = 32'd55;       bs[4] = 32'd0;        exps[4] = 32'hFFFFFFFF; lats[4] = 1;
    ops[5] = 3'b110; as[5] = 32'd5;        bs[5] = 32'd0;        exps[5] = 32'd5;        lats[5] = 1;
    ops[6] = 3'b100; as[6] = 32'h80000000; bs[6] = 32'hFFFFFFFF; exps[6] = 32'h80000000; lats[6] = 1;
`else
    ops[0] = 3'b100; as[0] = 32'd9;        bs[0] = 32'd3;        exps[0] = 32'd0; lats[0] = 1;
    ops[1] = 3'b110; as[1] = 32'hFFFFFFF9; bs[1] = 32'd2;        exps[1] = 32'd0; lats[1] = 1;
    ops[2] = 3'b101; as[2] = 32'd100;      bs[2] = 32'd7;        exps[2] = 32'd0; lats[2] = 1;
    ops[3] = 3'b111; as[3] = 32'd100;      bs[3] = 32'd7;        exps[3] = 32'd0; lats[3] = 1;
    ops[4] = 3'b101; as[4] = 32'd55;       bs[4] = 32'd0;        exps[4] = 32'd0; lats[4] = 1;
    ops[5] = 3'b110; as[5] = 32'd5;        bs[5] = 32'd0;        exps[5] = 32'd0; lats[5] = 1;
    ops[6] = 3'b100; as[6] = 32'h80000000; bs[6] = 32'hFFFFFFFF; exps[6] = 32'd0; lats[6] = 1;
`endif
    // Preload a nonzero result so a zero from a divide is distinguishable.
    do_op(3'b000, 32'd3, 32'd5, 5'd1, res, rdo, lat, sb);
    for (int k = 0; k < 7; k++) begin
      do_op(ops[k], as[k], bs[k], 5'(k + 20), res, rdo, lat, sb);
      checks++; if (res !== exps[k]) begin errors++; $display("FAIL div_res[%0d] got %h exp %h", k, res, exps[k]); end
      checks++; if (lat != lats[k]) begin errors++; $display("FAIL div_lat[%0d] got %0d exp %0d", k, lat, lats[k]); end
      checks++; if (sb != 0) begin errors++; $display("FAIL div_stall[%0d] got %0d bad cycles exp 0", k, sb); end
      checks++; if (rdo !== 5'(k + 20)) begin errors++; $display("FAIL div_rd[%0d] got %0d exp %0d", k, rdo, k + 20); end
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0, t1 = 0, t2 = 0;
    logic [31:0] r1 = '0, r2 = '0;
    logic [4:0]  rd2 = '0;
    @(negedge clk_i);
    op_i = 3'b000; RS1_i = 32'd7; RS2_i = 32'd6; RDaddr_i = 5'd3; start_i = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          t1 = i; r1 = result_o;
          RS1_i = 32'd3; RS2_i = 32'd3; RDaddr_i = 5'd9;
        end else if (pulses == 2) begin
          t2 = i; r2 = result_o; rd2 = RDaddr_o;
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    checks++; if (t1 != 33) begin errors++; $display("FAIL b2b_t1 got %0d exp 33", t1); end
    checks++; if (t2 != 67) begin errors++; $display("FAIL b2b_t2 got %0d exp 67", t2); end
    checks++; if (r1 !== 32'd42) begin errors++; $display("FAIL b2b_r1 got %h exp 2a", r1); end
    checks++; if (r2 !== 32'd9) begin errors++; $display("FAIL b2b_r2 got %h exp 9", r2); end
    checks++; if (rd2 !== 5'd9) begin errors++; $display("FAIL b2b_rd got %0d exp 9", rd2); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0, stalls = 0;
    @(negedge clk_i);
    op_i = 3'b000; RS1_i = 32'd7; RS2_i = 32'd6; RDaddr_i = 5'd12; start_i = 1'b1;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", done_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h exp 0", result_o); end
    checks++; if (RDaddr_o !== 5'h0) begin errors++; $display("FAIL rstmid_rd got %h exp 0", RDaddr_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) pulses++;
      if (stall_o !== 1'b0) stalls++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", pulses); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL rstmid_no_stall got %0d exp 0", stalls); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
